// File: rtl/vram_frame_writer.sv
// Write side of the double-buffered frame store. Accepts a pixel stream, fills the
// back buffer (~out_front_sel) through the shared VRAM write port, then flips
// front/back once the frame is complete and the reader reports a safe swap point.
module vram_frame_writer #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FRAME_PIXELS = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_ready,
    input  logic                  in_swap_ok,
    output logic                  out_wr0,
    output logic                  out_wr1,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data,
    output logic                  out_front_sel,
    output logic                  out_busy,
    output logic                  out_frame_done
);

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWriting,
        StWaitSwap,
        StSwap
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  front_q, front_d;
    logic                  wr0_q, wr0_d;
    logic                  wr1_q, wr1_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Next-state logic: frame sequencing, pixel counting and the registered write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        front_d = front_q;
        wr0_d   = 1'b0;
        wr1_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (in_start) begin
                    state_d = StWriting;
                    cnt_d   = '0;
                end
            end
            StWriting: begin
                if (in_valid) begin
                    addr_d = cnt_q;
                    data_d = in_data;
                    // Target is the back buffer; front_q cannot change until SWAP.
                    wr1_d  = ~front_q;
                    wr0_d  = front_q;
                    cnt_d  = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LastIdx) begin
                        state_d = StWaitSwap;
                    end
                end
            end
            StWaitSwap: begin
                if (in_swap_ok) begin
                    state_d = StSwap;
                    // Toggle on entry so the new select is visible with the done pulse.
                    front_d = ~front_q;
                end
            end
            StSwap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; a write pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            front_q <= 1'b0;
            wr0_q   <= 1'b0;
            wr1_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            front_q <= front_d;
            wr0_q   <= wr0_d;
            wr1_q   <= wr1_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Outputs: handshake and status decode from state, write port from registers.
    always_comb begin
        out_ready      = (state_q == StWriting);
        out_busy       = (state_q != StIdle);
        out_frame_done = (state_q == StSwap);
        out_front_sel  = front_q;
        out_wr0        = wr0_q;
        out_wr1        = wr1_q;
        out_wr_addr    = addr_q;
        out_wr_data    = data_q;
    end

endmodule

// File: tb/tb_vram_frame_writer.sv
// Randomised bench for vram_frame_writer: a frame-level reference model predicts every
// output each cycle, two shadow VRAMs capture the writes, and directed literal checks
// pin frame latency, buffer selection and reset behaviour.
module tb_vram_frame_writer;

    localparam int FP = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_swap_ok = 1'b0;
    logic       out_ready, out_wr0, out_wr1, out_front_sel, out_busy, out_frame_done;
    logic [11:0] out_wr_addr;
    logic [7:0]  out_wr_data;

    vram_frame_writer #(
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (8),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_start      (in_start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_ready     (out_ready),
        .in_swap_ok    (in_swap_ok),
        .out_wr0       (out_wr0),
        .out_wr1       (out_wr1),
        .out_wr_addr   (out_wr_addr),
        .out_wr_data   (out_wr_data),
        .out_front_sel (out_front_sel),
        .out_busy      (out_busy),
        .out_frame_done(out_frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle", name, act, exp);
        end
    endtask

    // Reference model: a frame is "open" from start until swap; pixels accepted while
    // fewer than FP have been taken; swap one cycle after swap_ok seen with frame full.
    bit         m_inframe = 1'b0;
    bit         m_swap = 1'b0;
    bit         m_front = 1'b0;
    int         m_n = 0;
    bit         e_wr0 = 1'b0;
    bit         e_wr1 = 1'b0;
    logic [11:0] e_addr = '0;
    logic [7:0]  e_data = '0;
    int         cyc = 0;
    int         last_acc = 0;
    logic [7:0] m_img[FP];

    always @(posedge clk) begin
        bit acc;
        cyc++;
        if (rst) begin
            m_inframe = 1'b0;
            m_swap    = 1'b0;
            m_front   = 1'b0;
            m_n       = 0;
            e_wr0     = 1'b0;
            e_wr1     = 1'b0;
            e_addr    = '0;
            e_data    = '0;
        end else begin
            acc   = m_inframe && (m_n < FP) && in_valid;
            e_wr0 = 1'b0;
            e_wr1 = 1'b0;
            if (acc) begin
                e_addr     = 12'(m_n);
                e_data     = in_data;
                e_wr1      = !m_front;
                e_wr0      = m_front;
                m_img[m_n] = in_data;
                if (m_n == FP - 1) last_acc = cyc - 1;
                m_n++;
            end else if (m_swap) begin
                m_swap = 1'b0;
            end else if (m_inframe && m_n == FP && in_swap_ok) begin
                m_swap    = 1'b1;
                m_inframe = 1'b0;
                m_front   = !m_front;
            end else if (!m_inframe && in_start) begin
                m_inframe = 1'b1;
                m_n       = 0;
            end
        end
    end

    // Shadow VRAMs and strobe counters, plus the every-cycle model comparison.
    logic [7:0] mem0[FP];
    logic [7:0] mem1[FP];
    int n_wr0 = 0;
    int n_wr1 = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", 32'(out_ready), 32'(m_inframe && m_n < FP));
            chk("busy", 32'(out_busy), 32'(m_inframe || m_swap));
            chk("wr0", 32'(out_wr0), 32'(e_wr0));
            chk("wr1", 32'(out_wr1), 32'(e_wr1));
            chk("wr_addr", 32'(out_wr_addr), 32'(e_addr));
            chk("wr_data", 32'(out_wr_data), 32'(e_data));
            chk("front_sel", 32'(out_front_sel), 32'(m_front));
            chk("frame_done", 32'(out_frame_done), 32'(m_swap));
            if (out_wr0 === 1'b1) begin
                mem0[out_wr_addr] = out_wr_data;
                n_wr0++;
            end
            if (out_wr1 === 1'b1) begin
                mem1[out_wr_addr] = out_wr_data;
                n_wr1++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        tick();
        in_start = 1'b1;
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
        tick();
        in_start = 1'b0;
        in_valid = 1'b0;
    endtask

    // Feed pixels until the model has accepted `target`, with optional in_start noise.
    task automatic drive_frame(input int vprob, input bit addr_data, input bit noise,
                               input int target);
        for (int i = 0; i < 40000 && m_n < target; i++) begin
            in_valid = ($urandom_range(99) < vprob);
            in_data  = addr_data ? 8'(m_n) : 8'($urandom);
            in_start = noise && ($urandom_range(7) == 0);
            tick();
        end
        in_valid = 1'b0;
        in_start = 1'b0;
        if (m_n < target) begin
            errors++;
            $display("FAIL fill_timeout got %0d expected %0d", m_n, target);
        end
    endtask

    task automatic wait_done(output int t);
        bit found = 1'b0;
        t = -1;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (out_frame_done === 1'b1) begin
                found = 1'b1;
                t = cyc;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_timeout got 0 expected 1");
        end
    endtask

    task automatic cmp_mem(input string name, input bit which);
        int bad = 0;
        for (int i = 0; i < FP; i++) begin
            if ((which ? mem1[i] : mem0[i]) !== m_img[i]) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    int t_done;
    int t_raise;
    int bad;
    logic front_hold;

    initial begin
        repeat (3) tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_front", 32'(out_front_sel), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_strobes", 32'({out_wr0, out_wr1}), 32'd0);

        // Frame 1: back-to-back, data = addr[7:0], swap already permitted.
        in_swap_ok = 1'b1;
        start_frame();
        n_wr0 = 0;
        n_wr1 = 0;
        drive_frame(100, 1'b1, 1'b0, FP);
        wait_done(t_done);
        chk("f1_latency", 32'(t_done - last_acc), 32'd2);
        chk("f1_wr1_count", 32'(n_wr1), 32'd4096);
        chk("f1_wr0_count", 32'(n_wr0), 32'd0);
        chk("f1_front", 32'(out_front_sel), 32'd1);
        bad = 0;
        for (int i = 0; i < FP; i++) begin
            logic [11:0] a;
            a = 12'(i);
            if (mem1[i] !== a[7:0]) bad++;
        end
        chk("f1_image", 32'(bad), 32'd0);

        // Frame 2: random data, start noise; lands in frame 0, reader flips back.
        start_frame();
        n_wr0 = 0;
        n_wr1 = 0;
        drive_frame(100, 1'b0, 1'b1, FP);
        wait_done(t_done);
        chk("f2_front", 32'(out_front_sel), 32'd0);
        chk("f2_wr0_count", 32'(n_wr0), 32'd4096);
        chk("f2_wr1_count", 32'(n_wr1), 32'd0);
        cmp_mem("f2_reader_view", out_front_sel);

        // Frame 3: ~50% valid, swap held off 100 cycles after the last pixel.
        in_swap_ok = 1'b0;
        start_frame();
        n_wr0 = 0;
        n_wr1 = 0;
        drive_frame(50, 1'b0, 1'b1, FP);
        tick();
        front_hold = out_front_sel;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            in_start = 1'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            if (out_ready !== 1'b0 || out_busy !== 1'b1 || out_wr0 !== 1'b0 ||
                out_wr1 !== 1'b0 || out_front_sel !== front_hold) bad++;
        end
        in_start = 1'b0;
        in_valid = 1'b0;
        chk("f3_hold", 32'(bad), 32'd0);
        chk("f3_hold_front", 32'(front_hold), 32'd0);
        tick();
        in_swap_ok = 1'b1;
        t_raise = cyc;
        wait_done(t_done);
        chk("f3_swap_latency", 32'(t_done - t_raise), 32'd1);
        chk("f3_wr1_count", 32'(n_wr1), 32'd4096);
        cmp_mem("f3_image", 1'b1);

        // in_valid in IDLE is ignored, then reset after 1000 pixels of frame 4.
        tick();
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        start_frame();
        drive_frame(100, 1'b0, 1'b0, 1000);
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(out_busy), 32'd0);
        chk("rst_mid_front", 32'(out_front_sel), 32'd0);
        chk("rst_mid_strobes", 32'({out_wr0, out_wr1}), 32'd0);
        start_frame();
        drive_frame(100, 1'b0, 1'b0, 1);
        @(negedge clk);
        chk("restart_wr1", 32'(out_wr1), 32'd1);
        chk("restart_addr", 32'(out_wr_addr), 32'd0);
        drive_frame(70, 1'b0, 1'b0, FP);
        wait_done(t_done);
        chk("f5_front", 32'(out_front_sel), 32'd1);
        cmp_mem("f5_image", 1'b1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_frame_writer.md
Name: vram_frame_writer

Overview:
- Write-side counterpart of the double-buffered frame reader: accepts a pixel stream and fills the back frame buffer through the VRAM write ports (wr / wr_addr / in_data).
- Publishes the frame-select bit the reader muxes on. Flips front/back only after a complete frame is written and the reader signals a safe swap point.
- Sits between the paint/command logic (pixel producer) and the two VRAM instances.

Parameters:
- ADDR_WIDTH, 12, VRAM byte-address width (64 rows x 64 bytes).
- DATA_WIDTH, 8, pixel width; matches the VRAM in_data width.
- FRAME_PIXELS, 4096, pixels per frame; must be <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_start  input  1  start-of-frame request; sampled only in IDLE.
- in_valid  input  1  producer has a pixel on in_data.
- in_data  input  DATA_WIDTH  pixel value.
- out_ready  output  1  writer accepts a pixel this cycle.
- in_swap_ok  input  1  reader is at a safe point (between frames); level.
- out_wr0  output  1  write strobe, VRAM frame 0.
- out_wr1  output  1  write strobe, VRAM frame 1.
- out_wr_addr  output  ADDR_WIDTH  write address, shared by both VRAMs.
- out_wr_data  output  DATA_WIDTH  write data, shared by both VRAMs.
- out_front_sel  output  1  frame the reader displays; writes target ~out_front_sel.
- out_busy  output  1  high in any state except IDLE.
- out_frame_done  output  1  one-cycle pulse in the cycle out_front_sel toggles.

Behaviour:
- Reset values: all outputs 0. out_front_sel=0, so frame 1 is the back buffer. State=IDLE, pixel counter=0.
- State machine:
  - IDLE: out_ready=0. in_start=1 -> WRITING, counter=0.
  - WRITING: out_ready=1, driven combinationally from state. Handshake accepted when in_valid & out_ready.
  - WAIT_SWAP: out_ready=0. in_swap_ok=1 -> SWAP.
  - SWAP: toggle out_front_sel, out_frame_done=1 for one cycle, -> IDLE.
- Write path: each accepted pixel is registered. In the next cycle:
  - out_wr_addr = counter value at acceptance;
  - out_wr_data = accepted pixel;
  - exactly one strobe high: out_wr1 if out_front_sel=0, else out_wr0.
  - Latency is 1 cycle. Strobes are low in any cycle with no accepted pixel in the prior cycle; address and data hold their last values.
- Counter: increments by 1 per accepted pixel, width ADDR_WIDTH. It never wraps inside a frame.
- Last pixel: accepted with counter = FRAME_PIXELS-1 -> next state WAIT_SWAP, so out_ready is low the following cycle. That final write is still issued in the next cycle.
- in_swap_ok already high on WAIT_SWAP entry: SWAP on the next cycle. Minimum last-accept to out_frame_done is 2 cycles.
- Back-buffer target is fixed at frame start. out_front_sel only changes in SWAP, so a frame is never split across buffers.
- Stalls: in_valid low in WRITING inserts gaps. No timeout.
- Ignored inputs:
  - in_start outside IDLE is ignored, including in the SWAP cycle.
  - in_valid outside WRITING is ignored; no write is issued.
- Simultaneous events:
  - in_start and in_valid in the same IDLE cycle: only the transition occurs. First accept is the next cycle.
- Reset mid-frame: immediate return to IDLE, strobes 0, out_front_sel=0. Partially written VRAM contents are left as is (no clear).
- A write registered in the cycle rst is asserted is dropped.

Test Plan:
- Reset, then in_start and 4096 back-to-back pixels (data = addr[7:0]) with in_swap_ok=1 -> out_wr1 high for 4096 consecutive cycles, addr 0..4095, out_wr0 never high, out_frame_done 2 cycles after last accept, out_front_sel=1.
- Second frame after the first -> all writes on out_wr0, out_front_sel returns to 0 after done. Verify the reader mux selects the new frame.
- in_valid toggled on a random ~50% pattern -> exactly 4096 writes with contiguous addresses, no duplicates, data matches input order.
- in_swap_ok held low for 100 cycles after the last pixel -> out_ready=0, out_busy=1, no strobes, out_front_sel stable. Raise in_swap_ok -> done pulse 1 cycle later.
- rst asserted after 1000 pixels -> next cycle: IDLE, out_front_sel=0, no strobes. A new in_start restarts at addr 0 on frame 1.
- in_start pulsed during WRITING and WAIT_SWAP, in_valid during IDLE -> no effect on counter, strobes or state.
